axi4_lite_sram_slave: RTL
=========================

AXI4_LITE_SRAM_SLAVE -- requirements
Module: axi4_lite_sram_slave

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 1024, number of 32-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- R_DELAY, 1, clock edges from AR handshake to RVALID rise; legal range 1..255.
- W_DELAY, 1, clock edges from last of AW/W handshakes to BVALID rise; legal range 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- ARVALID in 1, ARREADY out 1, ARADDR in 32: read address channel.
- RVALID out 1, RREADY in 1, RDATA out 32, RRESP out 2: read data channel.
- AWVALID in 1, AWREADY out 1, AWADDR in 32: write address channel.
- WVALID in 1, WREADY out 1, WDATA in 32, WSTRB in 4: write data channel.
- BVALID out 1, BREADY in 1, BRESP out 2: write response channel.

Function
REQ-003 A handshake SHALL complete on a rising edge where VALID and READY are both high; VALID-to-READY dependency SHALL NOT exist (READY driven from state only).
REQ-004 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; in-range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH (32-bit unsigned compare).
REQ-005 Read FSM states: R_IDLE, R_WAIT, R_RESP; independent of write FSM.
- R_IDLE: ARREADY=1; on AR handshake capture ARADDR, load counter with R_DELAY, go R_WAIT.
- R_WAIT: ARREADY=0; decrement each edge; on edge where counter==1, load RDATA/RRESP, go R_RESP.
- R_RESP: RVALID=1, RDATA/RRESP stable until R handshake, then R_IDLE.
REQ-006 RVALID SHALL first be high R_DELAY edges after the AR handshake edge; no new AR accepted until R handshake (one outstanding read).
REQ-007 In-range read: RDATA = mem[index], RRESP=2'b00; out-of-range: RDATA=0, RRESP=2'b11 (DECERR).
REQ-008 Write FSM states: W_IDLE, W_WAIT, W_RESP.
- W_IDLE: AWREADY=1 until AW captured, WREADY=1 until W captured; AW and W accepted in either order or same edge; once both captured, load counter with W_DELAY, go W_WAIT.
- W_WAIT: AWREADY=WREADY=0; on edge where counter==1 commit write, go W_RESP.
- W_RESP: BVALID=1, BRESP stable until B handshake, then W_IDLE, clear capture flags.
REQ-009 Commit SHALL update only bytes lanes i where WSTRB[i]=1 (lane i = bits 8i+7:8i); WSTRB=0 writes nothing, BRESP=2'b00.
REQ-010 Out-of-range write SHALL not modify memory; BRESP=2'b11.
REQ-011 Read data load and write commit on the same edge to the same word: RDATA SHALL return the pre-write value.
REQ-012 R_DELAY=1 or W_DELAY=1 SHALL skip no state: R_WAIT/W_WAIT last exactly one cycle.

Reset
REQ-013 rst high SHALL immediately (no clock needed) force R_IDLE, W_IDLE, counters=0, capture flags=0; outputs ARREADY=1, AWREADY=1, WREADY=1, RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0.
REQ-014 Reset mid-transaction SHALL abandon it with no response and no memory commit; memory contents SHALL NOT be cleared by reset.

Verification
REQ-015 Write 0x8000_0010 data 0xDEADBEEF WSTRB 4'hF, AW/W same cycle -> BVALID rises W_DELAY edges later, BRESP=0; then read same addr -> RVALID R_DELAY edges after AR, RDATA=0xDEADBEEF, RRESP=0.
REQ-016 W presented 3 cycles before AW, WSTRB=4'b0101, data 0x11223344 over 0xDEADBEEF -> readback 0xDE22BE44.
REQ-017 Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) -> RRESP=2'b11, RDATA=0; BRESP=2'b11; prior word at 0x8000_0FFC unchanged.
REQ-018 RREADY/BREADY held low 5 cycles -> RVALID/BVALID and data stay stable, ARREADY/AWREADY/WREADY stay 0 until handshake.
REQ-019 R_DELAY=W_DELAY=3, read and write of 0x8000_0020 aligned to finish same edge, old value 0x0 new 0xA5A5A5A5 -> RDATA=0x0; subsequent read 0xA5A5A5A5.
REQ-020 rst asserted in W_WAIT after write 0x12345678 to 0x8000_0004 (old 0xCAFEF00D), mid-clock -> outputs reach reset values before next edge, no BVALID; readback 0xCAFEF00D.

Source files
------------

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM array.
// Read and write paths are independent FSMs, each with a programmable response delay.
module axi4_lite_sram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned R_DELAY   = 1,
  parameter int unsigned W_DELAY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP
);

  localparam int unsigned IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Offset taken modulo 2^32, so the upper bound never overflows.
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;

  w_state_t    w_state;
  logic [7:0]  w_cnt;
  logic        aw_done;
  logic        w_done;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic aw_hs;
  logic w_hs;
  logic commit;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign commit = (w_state == W_WAIT) && (w_cnt == 8'd1) && in_range(w_addr);

  // Read path: one outstanding read, data sampled on the edge the countdown expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            r_addr  <= ARADDR;
            r_cnt   <= 8'(R_DELAY);
            ARREADY <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 8'd1) begin
            r_cnt  <= '0;
            RVALID <= 1'b1;
            if (in_range(r_addr)) begin
              RDATA <= mem[word_idx(r_addr)];
              RRESP <= RESP_OKAY;
            end else begin
              RDATA <= '0;
              RRESP <= RESP_DECERR;
            end
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write path: AW and W captured independently, then a timed commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      AWREADY <= 1'b1;
      WREADY  <= 1'b1;
      BVALID  <= 1'b0;
      BRESP   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_done <= 1'b1;
            w_addr  <= AWADDR;
          end
          if (w_hs) begin
            w_done <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            w_cnt   <= 8'(W_DELAY);
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            w_state <= W_WAIT;
          end else begin
            AWREADY <= !(aw_done || aw_hs);
            WREADY  <= !(w_done || w_hs);
          end
        end
        W_WAIT: begin
          if (w_cnt == 8'd1) begin
            w_cnt   <= '0;
            BVALID  <= 1'b1;
            BRESP   <= in_range(w_addr) ? RESP_OKAY : RESP_DECERR;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 8'd1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; only strobed byte lanes are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule
